// File: rtl/dectomux_arbiter_if.sv
// Handshake/data bundle between requesters and the 4:1 round-robin mux arbiter.
// The master side drives requests and data; the slave side (arbiter) drives grant and mux output.
interface dectomux_arbiter_if;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       y_valid;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  y,
        input  y_valid
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output y,
        output y_valid
    );
endinterface

// File: rtl/dectomux_arbiter.sv
// Round-robin arbiter over four requesters with burst limiting, steering the
// granted requester's data bit through a registered 4:1 mux.
module dectomux_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    dectomux_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] burst_q, burst_d;
    logic       y_q, y_d;
    logic       y_valid_q, y_valid_d;

    logic [3:0] holder_oh;
    logic       holding;
    logic       others;
    logic [3:0] arb_req;
    logic       win_found;
    logic [1:0] win_idx;

    always_comb begin
        holder_oh = 4'b0001 << sel_q;
        holding   = bus.req[sel_q];
        others    = |(bus.req & ~holder_oh);
        // Only a burst-limited holder is masked out; otherwise its bit is already clear or it is idle.
        arb_req   = (state_q == BUSY && holding) ? (bus.req & ~holder_oh) : bus.req;

        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!win_found && arb_req[ptr_q + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        y_d       = bus.din[sel_q];
        y_valid_d = (state_q == BUSY) && holding;

        if (state_q == BUSY && holding && burst_q < MAX_CNT) begin
            burst_d = burst_q + 4'd1;
        end else if (state_q == BUSY && holding && !others) begin
            burst_d = 4'd1;
        end else if (win_found) begin
            state_d = BUSY;
            gnt_d   = 4'b0001 << win_idx;
            sel_d   = win_idx;
            ptr_d   = win_idx + 2'd1;
            burst_d = 4'd1;
        end else if (state_q == BUSY) begin
            state_d = IDLE;
            gnt_d   = '0;
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            burst_q   <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule
